// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stop/no-stop levels,
// exception codes, FSM state encodings and the stall-priority encoder.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
  localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  typedef enum logic {
    RUN    = 1'b0,
    REFILL = 1'b1
  } state_t;

  // A stall from stage k freezes stage k and every stage upstream of it
  function automatic logic [5:0] stall_mask(input logic req_mem, input logic req_ex,
                                            input logic req_id, input logic req_if);
    logic [5:0] m;
    m = {6{NO_STOP}};
    if (req_mem)     m = {NO_STOP, {5{STOP}}};
    else if (req_ex) m = {{2{NO_STOP}}, {4{STOP}}};
    else if (req_id) m = {{3{NO_STOP}}, {3{STOP}}};
    else if (req_if) m = {{4{NO_STOP}}, {2{STOP}}};
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count events, stick at all-ones, clear takes priority over an event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stall requests, turns mem-stage exceptions
// into flush + redirect, sequences post-flush refill, counts stalls/flushes.
// Optional watchdog on long stall runs is enabled by PIPE_CTRL_WDT_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          REFILL_CYCLES = 2,
  parameter int          CNT_W         = 16,
  parameter int          WDT_LIMIT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             cnt_clr,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wdt_timeout
);
  import pipe_ctrl_pkg::*;

  localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [RW-1:0] REFILL_LOAD = RW'(REFILL_CYCLES - 1);

  if (REFILL_CYCLES < 1 || WDT_LIMIT < 1) begin : g_bad_param
    $error("pipe_ctrl: REFILL_CYCLES and WDT_LIMIT must be at least 1");
  end

  state_t        state, next_state;
  logic [RW-1:0] rcnt, next_rcnt;
  logic [5:0]    req_stall;

  // State register and refill down-counter; reset aborts any refill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      rcnt  <= '0;
    end else begin
      state <= next_state;
      rcnt  <= next_rcnt;
    end
  end

  // Next state and zero-latency stall/flush/redirect outputs
  always_comb begin
    next_state = state;
    next_rcnt  = rcnt;
    stall      = '0;
    flush      = 1'b0;
    new_pc     = '0;
    req_stall  = stall_mask(stallreq_from_mem, stallreq_from_ex,
                            stallreq_from_id, stallreq_from_if);
    case (state)
      RUN: begin
        if (excepttype_i != EXC_NONE) begin
          flush      = 1'b1;
          new_pc     = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          next_state = REFILL;
          next_rcnt  = REFILL_LOAD;
        end else begin
          stall = req_stall;
        end
      end
      REFILL: begin
        stall = req_stall;
        if (rcnt == '0) next_state = RUN;
        else            next_rcnt  = rcnt - 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall != '0), .clr(cnt_clr), .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush), .clr(cnt_clr), .count(flush_cnt)
  );

`ifdef PIPE_CTRL_WDT_EN
  localparam int WW = $clog2(WDT_LIMIT + 1);
  logic [WW-1:0] run_cnt;

  sat_counter #(.W(WW)) u_wdt_run (
    .clk(clk), .rst(rst), .inc(stall != '0), .clr((stall == '0) || cnt_clr),
    .count(run_cnt)
  );

  // Sticky flag set on the edge where the run counter reaches WDT_LIMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                 wdt_timeout <= 1'b0;
    else if (cnt_clr)                                         wdt_timeout <= 1'b0;
    else if ((stall != '0) && (run_cnt == WW'(WDT_LIMIT - 1))) wdt_timeout <= 1'b1;
  end
`else
  assign wdt_timeout = 1'b0;
`endif

endmodule
